// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: FSM states and store sizes.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // funct3 encodings of the access size
    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

endpackage

// File: rtl/store_align.sv
// Store lane replication: copies the low byte/half of the store data into
// every lane so the slave can pick the addressed lane with the byte strobes.
module store_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_rep
);

    // Replicate according to access size; words pass through untouched
    always_comb begin
        wdata_rep = wdata;
        case (funct3)
            SIZE_B:  wdata_rep = {4{wdata[7:0]}};
            SIZE_H:  wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to memory-bus bridge. Holds the pipeline (stall_m) while a load or
// store is carried out on a req/gnt/rvalid bus, with a per-phase timeout that
// aborts the access and raises a sticky bus_err.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        mem_write_m,
    input  logic        mem_read_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic [3:0]  byte_en_m,
    output logic [31:0] rd_data,
    output logic        stall_m,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          access;
    logic          latch;
    logic          capture;
    logic          abort;
    logic          last_cycle;
    logic [31:0]   wdata_rep;

    store_align u_store_align (
        .funct3    (funct3_m),
        .wdata     (wdata_m),
        .wdata_rep (wdata_rep)
    );

    // A store with no strobes is a no-op and never reaches the bus
    assign access     = (mem_read_m | mem_write_m) & (|byte_en_m);
    assign last_cycle = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, stall and bus request; grant wins over a same-cycle timeout
    always_comb begin
        state_nxt = state;
        stall_m   = 1'b0;
        bus_req   = 1'b0;
        latch     = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    stall_m   = 1'b1;
                    latch     = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_m = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) begin
                    if (bus_we) begin
                        state_nxt = ST_DONE;
                    end else if (bus_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_R;
                    end
                end else if (last_cycle) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT_R: begin
                stall_m = 1'b1;
                if (bus_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (last_cycle) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait counter restarts on every state change and runs only in REQ/WAIT_R
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == ST_REQ || state == ST_WAIT_R) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Latched request fields, captured read word and sticky error flag
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            rd_data   <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            if (latch) begin
                bus_we    <= mem_write_m;
                bus_be    <= byte_en_m;
                bus_addr  <= addr_m & 32'hFFFF_FFFC;
                bus_wdata <= wdata_rep;
            end
            if (capture)    rd_data <= bus_rdata;
            else if (abort) rd_data <= 32'h0;
            if (abort) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: stores of each size, loads with delayed,
// same-cycle and missing grants, stray rvalid, timeout and mid-access reset.
module tb_dmem_bridge;
    import dmem_pkg::*;

    logic        clk;
    logic        clr_n;
    logic        mem_write_m;
    logic        mem_read_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic [3:0]  byte_en_m;
    logic [31:0] rd_data;
    logic        stall_m;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Results recorded by the access task
    int          stalls;
    int          req_cycles;
    logic [31:0] first_addr;
    logic [31:0] first_wdata;
    logic [3:0]  first_be;
    logic        first_we;
    logic [31:0] done_rd;
    logic        done_req;
    logic        done_err;
    logic        idle_stall;
    logic        idle_req;

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .mem_write_m (mem_write_m),
        .mem_read_m  (mem_read_m),
        .funct3_m    (funct3_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .byte_en_m   (byte_en_m),
        .rd_data     (rd_data),
        .stall_m     (stall_m),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one access and act as the bus slave. Cycle 0 is the IDLE cycle;
    // gnt is high in cycle gnt_cyc, rvalid with rdat in cycle rv_cyc, and a
    // junk rvalid in cycle stray_cyc (negative = never).
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input int gnt_cyc, input int rv_cyc, input logic [31:0] rdat,
                          input int stray_cyc);
        int  c;
        bit  seen;
        mem_write_m = wr;
        mem_read_m  = ~wr;
        funct3_m    = f3;
        addr_m      = a;
        wdata_m     = d;
        byte_en_m   = be;
        stalls      = 0;
        req_cycles  = 0;
        seen        = 0;
        c           = 0;
        forever begin
            bus_gnt    = (c == gnt_cyc);
            bus_rvalid = (c == rv_cyc) || (c == stray_cyc);
            bus_rdata  = (c == rv_cyc) ? rdat : 32'hBADB_AD00;
            #1;
            if (!stall_m) break;
            stalls++;
            if (bus_req) begin
                req_cycles++;
                if (!seen) begin
                    seen        = 1;
                    first_addr  = bus_addr;
                    first_wdata = bus_wdata;
                    first_be    = bus_be;
                    first_we    = bus_we;
                end
            end
            if (c >= 40) begin
                check("stall_bound", {31'b0, stall_m}, 32'h0);
                break;
            end
            tick();
            c++;
        end
        done_rd     = rd_data;
        done_req    = bus_req;
        done_err    = bus_err;
        mem_write_m = 1'b0;
        mem_read_m  = 1'b0;
        byte_en_m   = 4'b0000;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
        tick();
        #1;
        idle_stall = stall_m;
        idle_req   = bus_req;
    endtask

    initial begin
        clr_n       = 1'b1;
        mem_write_m = 1'b0;
        mem_read_m  = 1'b0;
        funct3_m    = SIZE_W;
        addr_m      = 32'h0;
        wdata_m     = 32'h0;
        byte_en_m   = 4'b0000;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 32'h0;
        #1 clr_n = 1'b0;

        // Reset state, with a load presented to exercise stall during reset
        mem_read_m = 1'b1;
        byte_en_m  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req",   {31'b0, bus_req}, 32'h0);
        check("rst_bus_we",    {31'b0, bus_we},  32'h0);
        check("rst_bus_be",    {28'b0, bus_be},  32'h0);
        check("rst_bus_addr",  bus_addr,         32'h0);
        check("rst_bus_wdata", bus_wdata,        32'h0);
        check("rst_rd_data",   rd_data,          32'h0);
        check("rst_bus_err",   {31'b0, bus_err}, 32'h0);
        check("rst_stall_acc", {31'b0, stall_m}, 32'h1);
        mem_read_m = 1'b0;
        byte_en_m  = 4'b0000;
        #1;
        check("rst_stall_idle", {31'b0, stall_m}, 32'h0);
        clr_n = 1'b1;
        tick();

        // sw 0x100 <- 0xDEADBEEF, grant on first REQ cycle
        access(1'b1, SIZE_W, 32'h100, 32'hDEAD_BEEF, 4'hF, 1, -1, 32'h0, -1);
        check("sw_stalls", stalls,      32'd2);
        check("sw_addr",   first_addr,  32'h100);
        check("sw_be",     {28'b0, first_be}, 32'hF);
        check("sw_wdata",  first_wdata, 32'hDEAD_BEEF);
        check("sw_we",     {31'b0, first_we}, 32'h1);
        check("sw_done_req", {31'b0, done_req}, 32'h0);
        check("sw_idle_stall", {31'b0, idle_stall}, 32'h0);
        check("sw_idle_req",   {31'b0, idle_req},   32'h0);

        // sb 0x103 <- 0xA5
        access(1'b1, SIZE_B, 32'h103, 32'h0000_00A5, 4'b1000, 1, -1, 32'h0, -1);
        check("sb_stalls", stalls,      32'd2);
        check("sb_addr",   first_addr,  32'h100);
        check("sb_be",     {28'b0, first_be}, 32'h8);
        check("sb_wdata",  first_wdata, 32'hA5A5_A5A5);

        // sh 0x202 <- 0xBEEF, grant on second REQ cycle
        access(1'b1, SIZE_H, 32'h202, 32'h1234_BEEF, 4'b1100, 2, -1, 32'h0, -1);
        check("sh_stalls",  stalls,      32'd3);
        check("sh_req_cyc", req_cycles,  32'd2);
        check("sh_addr",    first_addr,  32'h200);
        check("sh_wdata",   first_wdata, 32'hBEEF_BEEF);

        // Store with no strobes completes in IDLE without touching the bus
        access(1'b1, SIZE_W, 32'h400, 32'h1111_1111, 4'b0000, 1, -1, 32'h0, -1);
        check("be0_stalls",  stalls,     32'd0);
        check("be0_req_cyc", req_cycles, 32'd0);
        check("be0_req",     {31'b0, done_req}, 32'h0);

        // lw, grant on third REQ cycle, rvalid two cycles later, stray rvalid in REQ
        access(1'b0, SIZE_W, 32'h500, 32'h0, 4'hF, 3, 5, 32'h1234_5678, 1);
        check("lw_stalls", stalls,  32'd6);
        check("lw_addr",   first_addr, 32'h500);
        check("lw_we",     {31'b0, first_we}, 32'h0);
        check("lw_rd",     done_rd, 32'h1234_5678);

        // lw with grant and rvalid together: WAIT_R skipped
        access(1'b0, SIZE_W, 32'h504, 32'h0, 4'hF, 1, 1, 32'hA5C3_0F96, -1);
        check("lw_fast_stalls", stalls,  32'd2);
        check("lw_fast_rd",     done_rd, 32'hA5C3_0F96);

        // rvalid while idle must not disturb rd_data
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBADB_AD00;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check("stray_rd",    rd_data, 32'hA5C3_0F96);
        check("stray_stall", {31'b0, stall_m}, 32'h0);
        check("err_clear",   {31'b0, bus_err}, 32'h0);

        // Grant never arrives: abort after 4 REQ cycles
        access(1'b0, SIZE_W, 32'h600, 32'h0, 4'hF, -1, -1, 32'h0, -1);
        check("to_stalls",   stalls,     32'd5);
        check("to_req_cyc",  req_cycles, 32'd4);
        check("to_done_req", {31'b0, done_req}, 32'h0);
        check("to_rd",       done_rd,    32'h0);
        check("to_err",      {31'b0, done_err}, 32'h1);
        check("to_idle_stall", {31'b0, idle_stall}, 32'h0);

        // Error flag is sticky across a later good load
        access(1'b0, SIZE_W, 32'h608, 32'h0, 4'hF, 1, 1, 32'h0F0F_1234, -1);
        check("sticky_rd",  done_rd, 32'h0F0F_1234);
        check("sticky_err", {31'b0, bus_err}, 32'h1);

        // Reset in WAIT_R, then a late rvalid after release
        mem_read_m = 1'b1;
        funct3_m   = SIZE_W;
        addr_m     = 32'h800;
        wdata_m    = 32'h7777_7777;
        byte_en_m  = 4'hF;
        #1;
        check("wr_idle_stall", {31'b0, stall_m}, 32'h1);
        tick();
        bus_gnt = 1'b1;
        #1;
        check("wr_req", {31'b0, bus_req}, 32'h1);
        tick();
        bus_gnt = 1'b0;
        #1;
        check("wr_wait_stall", {31'b0, stall_m}, 32'h1);
        check("wr_wait_req",   {31'b0, bus_req}, 32'h0);
        tick();
        clr_n = 1'b0;
        #1;
        check("mid_rst_req",   {31'b0, bus_req}, 32'h0);
        check("mid_rst_rd",    rd_data,   32'h0);
        check("mid_rst_addr",  bus_addr,  32'h0);
        check("mid_rst_wdata", bus_wdata, 32'h0);
        check("mid_rst_be",    {28'b0, bus_be}, 32'h0);
        check("mid_rst_err",   {31'b0, bus_err}, 32'h0);
        check("mid_rst_stall", {31'b0, stall_m}, 32'h1);
        mem_read_m = 1'b0;
        byte_en_m  = 4'b0000;
        @(negedge clk);
        clr_n = 1'b1;
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_0001;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check("late_rv_rd",    rd_data, 32'h0);
        check("late_rv_req",   {31'b0, bus_req}, 32'h0);
        check("late_rv_stall", {31'b0, stall_m}, 32'h0);

        // Bridge is usable again after reset
        access(1'b1, SIZE_W, 32'h700, 32'hCAFE_BABE, 4'hF, 1, -1, 32'h0, -1);
        check("post_stalls", stalls,      32'd2);
        check("post_addr",   first_addr,  32'h700);
        check("post_wdata",  first_wdata, 32'hCAFE_BABE);
        check("post_err",    {31'b0, bus_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
